// File: rtl/bus_arb_pkg.sv
// Shared types, defaults and helpers for the system bus arbiter family.
// Future interrupt/DMA arbiters import this too.
package bus_arb_pkg;

    localparam int DEF_NUM_REQ  = 5;
    localparam int DEF_ID_WIDTH = 3;
    localparam int MAX_REQ      = 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        OWN     = 2'd1,
        RELEASE = 2'd2
    } arb_state_t;

    // OR-reduction form keeps this a flat encoder; an all-zero input yields index 0.
    function automatic logic [DEF_ID_WIDTH-1:0] onehot_to_idx(input logic [MAX_REQ-1:0] oh);
        logic [DEF_ID_WIDTH-1:0] idx;
        idx = '0;
        for (int i = 0; i < MAX_REQ; i++) begin
            if (oh[i]) begin
                idx = idx | DEF_ID_WIDTH'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// Combinational rotating-priority picker: first asserted request at or above ptr, wrapping.
// Kept free of state so other arbiters can reuse it with their own pointer policy.
module rr_priority_pick
    import bus_arb_pkg::*;
#(
    parameter int NUM_REQ  = DEF_NUM_REQ,
    parameter int ID_WIDTH = DEF_ID_WIDTH
) (
    input  logic [NUM_REQ-1:0]  req_i,
    input  logic [ID_WIDTH-1:0] ptr_i,
    output logic [NUM_REQ-1:0]  winner_o,
    output logic [ID_WIDTH-1:0] winner_idx_o,
    output logic                any_req_o
);

    // One spare bit so ptr + offset cannot overflow before the wrap at NUM_REQ = 8.
    localparam int SUM_W = ID_WIDTH + 1;

    logic [SUM_W-1:0] cand;
    logic             found;

    always_comb begin
        winner_o     = '0;
        winner_idx_o = '0;
        found        = 1'b0;
        cand         = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = {1'b0, ptr_i} + SUM_W'(k);
            if (cand >= SUM_W'(NUM_REQ)) begin
                cand = cand - SUM_W'(NUM_REQ);
            end
            for (int j = 0; j < NUM_REQ; j++) begin
                if (!found && req_i[j] && (cand == SUM_W'(j))) begin
                    found        = 1'b1;
                    winner_o[j]  = 1'b1;
                    winner_idx_o = ID_WIDTH'(j);
                end
            end
        end
    end

    assign any_req_o = |req_i;

endmodule

// File: rtl/bus_arbiter_rr.sv
// Round-robin, transaction-holding system bus arbiter with an ownership watchdog.
// A granted master keeps the bus until it drops its request or the watchdog revokes it.
module bus_arbiter_rr
    import bus_arb_pkg::*;
#(
    parameter int NUM_REQ        = DEF_NUM_REQ,
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int ID_WIDTH       = DEF_ID_WIDTH
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NUM_REQ-1:0]  bus_reqcyc,
    input  logic                bus_busy,
    output logic [NUM_REQ-1:0]  bus_grant,
    output logic                grant_valid,
    output logic [ID_WIDTH-1:0] grant_id,
    output logic                timeout_err,
    output logic [ID_WIDTH-1:0] timeout_id
);

    localparam int                SUM_W     = ID_WIDTH + 1;
    localparam int                WDOG_W    = $clog2(TIMEOUT_CYCLES);
    localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(TIMEOUT_CYCLES - 1);

    arb_state_t          state_q, state_d;
    logic [NUM_REQ-1:0]  grant_q, grant_d;
    logic [ID_WIDTH-1:0] ptr_q, ptr_d;
    logic [WDOG_W-1:0]   wdog_q, wdog_d;
    logic                terr_q, terr_d;
    logic [ID_WIDTH-1:0] tid_q, tid_d;

    logic [NUM_REQ-1:0]  pick_oh;
    logic [ID_WIDTH-1:0] pick_idx;
    logic                pick_any;
    logic [SUM_W-1:0]    ptr_next;
    logic [ID_WIDTH-1:0] owner_idx;
    logic                owner_req;

    rr_priority_pick #(
        .NUM_REQ  (NUM_REQ),
        .ID_WIDTH (ID_WIDTH)
    ) u_pick (
        .req_i        (bus_reqcyc),
        .ptr_i        (ptr_q),
        .winner_o     (pick_oh),
        .winner_idx_o (pick_idx),
        .any_req_o    (pick_any)
    );

    assign owner_idx = ID_WIDTH'(onehot_to_idx(MAX_REQ'(grant_q)));
    assign owner_req = |(bus_reqcyc & grant_q);

    // Grant, watchdog and pointer policy. A request drop is tested before the
    // watchdog so a master finishing on its last allowed cycle is not flagged.
    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        ptr_d    = ptr_q;
        wdog_d   = wdog_q;
        terr_d   = 1'b0;
        tid_d    = tid_q;
        ptr_next = {1'b0, pick_idx} + SUM_W'(1);
        if (ptr_next == SUM_W'(NUM_REQ)) begin
            ptr_next = '0;
        end
        case (state_q)
            IDLE: begin
                if (!bus_busy && pick_any) begin
                    grant_d = pick_oh;
                    ptr_d   = ptr_next[ID_WIDTH-1:0];
                    wdog_d  = '0;
                    state_d = OWN;
                end
            end
            OWN: begin
                if (!owner_req) begin
                    grant_d = '0;
                    state_d = RELEASE;
                end else if (wdog_q == WDOG_LAST) begin
                    grant_d = '0;
                    terr_d  = 1'b1;
                    tid_d   = owner_idx;
                    state_d = RELEASE;
                end else begin
                    wdog_d = wdog_q + 1'b1;
                end
            end
            RELEASE: begin
                state_d = IDLE;
            end
            default: begin
                grant_d = '0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            grant_q <= '0;
            ptr_q   <= '0;
            wdog_q  <= '0;
            terr_q  <= 1'b0;
            tid_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            ptr_q   <= ptr_d;
            wdog_q  <= wdog_d;
            terr_q  <= terr_d;
            tid_q   <= tid_d;
        end
    end

    assign bus_grant   = grant_q;
    assign grant_valid = |grant_q;
    assign grant_id    = owner_idx;
    assign timeout_err = terr_q;
    assign timeout_id  = tid_q;

endmodule

// File: tb/tb_bus_arbiter_rr.sv
// Scoreboard bench for bus_arbiter_rr: a transaction-level model predicts grant,
// release and timeout events; a monitor checks each event as the DUT presents it.
module tb_bus_arbiter_rr;

    localparam int NUM_REQ  = 5;
    localparam int ID_WIDTH = 3;
    localparam int TIMEOUT  = 8;

    typedef struct {
        int id;
        int cyc;
    } evt_t;

    logic                clk;
    logic                reset;
    logic [NUM_REQ-1:0]  reqVec;
    logic                busyIn;
    logic [NUM_REQ-1:0]  bus_grant;
    logic                grant_valid;
    logic [ID_WIDTH-1:0] grant_id;
    logic                timeout_err;
    logic [ID_WIDTH-1:0] timeout_id;

    int checks = 0;
    int errors = 0;
    int cycleCount = 0;

    evt_t grantQ[$];
    evt_t releaseQ[$];
    evt_t timeoutQ[$];
    int   obsIds[$];

    // Reference model state: who owns the bus, for how many visible cycles,
    // whether the turnaround cycle is pending, and the rotating start index.
    int mOwner = -1;
    int mHeld  = 0;
    bit mDead  = 1'b0;
    int mPtr   = 0;
    int mTid   = 0;

    bus_arbiter_rr #(
        .NUM_REQ        (NUM_REQ),
        .TIMEOUT_CYCLES (TIMEOUT),
        .ID_WIDTH       (ID_WIDTH)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .bus_reqcyc  (reqVec),
        .bus_busy    (busyIn),
        .bus_grant   (bus_grant),
        .grant_valid (grant_valid),
        .grant_id    (grant_id),
        .timeout_err (timeout_err),
        .timeout_id  (timeout_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d (cycle %0d)", name, actual, expected, cycleCount);
        end
    endtask

    task automatic applyStimulus(input logic [NUM_REQ-1:0] r, input logic b, input logic rs, input int cycles);
        reqVec = r;
        busyIn = b;
        reset  = rs;
        repeat (cycles) @(negedge clk);
    endtask

    function automatic bit reqBit(input int idx);
        logic [NUM_REQ-1:0] v;
        v = reqVec >> idx;
        return v[0];
    endfunction

    // One model step per rising edge, using the inputs the DUT samples there.
    task automatic modelStep();
        int w;
        int c;
        if (reset) begin
            if (mOwner >= 0) releaseQ.push_back('{id: mOwner, cyc: cycleCount});
            mOwner = -1;
            mDead  = 1'b0;
            mPtr   = 0;
            mTid   = 0;
        end else if (mOwner >= 0) begin
            if (!reqBit(mOwner)) begin
                releaseQ.push_back('{id: mOwner, cyc: cycleCount});
                mOwner = -1;
                mDead  = 1'b1;
            end else if (mHeld == TIMEOUT) begin
                releaseQ.push_back('{id: mOwner, cyc: cycleCount});
                timeoutQ.push_back('{id: mOwner, cyc: cycleCount});
                mTid   = mOwner;
                mOwner = -1;
                mDead  = 1'b1;
            end else begin
                mHeld++;
            end
        end else if (mDead) begin
            mDead = 1'b0;
        end else if (!busyIn && reqVec != '0) begin
            w = -1;
            for (int k = 0; k < NUM_REQ; k++) begin
                c = (mPtr + k) % NUM_REQ;
                if (w < 0 && reqBit(c)) w = c;
            end
            mOwner = w;
            mHeld  = 1;
            mPtr   = (w + 1) % NUM_REQ;
            grantQ.push_back('{id: w, cyc: cycleCount});
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            cycleCount++;
            modelStep();
        end
    end

    // Monitor: every change of bus_grant and every timeout pulse consumes one event.
    initial begin
        logic [NUM_REQ-1:0] prevGrant;
        evt_t e;
        prevGrant = '0;
        forever begin
            @(negedge clk);
            if (bus_grant !== prevGrant) begin
                if (prevGrant != '0) begin
                    if (releaseQ.size() == 0) begin
                        checkOutput("release queue depth", releaseQ.size(), 1);
                    end else begin
                        e = releaseQ.pop_front();
                        checkOutput("release cycle", cycleCount, e.cyc);
                        checkOutput("release owner", int'(onehotIdx(prevGrant)), e.id);
                    end
                end
                if (bus_grant != '0) begin
                    if (grantQ.size() == 0) begin
                        checkOutput("grant queue depth", grantQ.size(), 1);
                    end else begin
                        e = grantQ.pop_front();
                        checkOutput("grant cycle", cycleCount, e.cyc);
                        checkOutput("grant vector", int'(bus_grant), 1 << e.id);
                        checkOutput("grant id", int'(grant_id), e.id);
                        checkOutput("grant valid", int'(grant_valid), 1);
                        checkOutput("timeout id held", int'(timeout_id), mTid);
                        obsIds.push_back(int'(grant_id));
                    end
                end else begin
                    checkOutput("idle grant id", int'(grant_id), 0);
                    checkOutput("idle grant valid", int'(grant_valid), 0);
                end
            end
            if (timeout_err !== 1'b0) begin
                if (timeoutQ.size() == 0) begin
                    checkOutput("timeout queue depth", timeoutQ.size(), 1);
                end else begin
                    e = timeoutQ.pop_front();
                    checkOutput("timeout cycle", cycleCount, e.cyc);
                    checkOutput("timeout id", int'(timeout_id), e.id);
                end
            end
            prevGrant = bus_grant;
        end
    end

    function automatic int onehotIdx(input logic [NUM_REQ-1:0] v);
        int idx;
        idx = -1;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (v[i]) idx = i;
        end
        return idx;
    endfunction

    initial begin
        #500000;
        $display("[TB] FAIL global time limit reached");
        $fatal(1, "[TB] simulation did not finish");
    end

    initial begin
        logic [NUM_REQ-1:0] dropMask;
        logic [NUM_REQ-1:0] r;
        int expOrder[6];
        int holdCnt[NUM_REQ];
        int o;
        int holdCycles;

        expOrder = '{0, 1, 2, 3, 4, 0};
        reqVec   = '1;
        busyIn   = 1'b0;
        reset    = 1'b1;

        // Reset with every master requesting: outputs stay zero throughout.
        applyStimulus(5'b11111, 1'b0, 1'b1, 3);
        checkOutput("reset bus_grant", int'(bus_grant), 0);
        checkOutput("reset grant_valid", int'(grant_valid), 0);
        checkOutput("reset grant_id", int'(grant_id), 0);
        checkOutput("reset timeout_err", int'(timeout_err), 0);
        checkOutput("reset timeout_id", int'(timeout_id), 0);

        applyStimulus(5'b11111, 1'b0, 1'b0, 1);
        checkOutput("first grant vector", int'(bus_grant), 1);
        checkOutput("first grant id", int'(grant_id), 0);

        // Full load: each owner holds three cycles, drops for one, re-requests.
        for (int g = 0; g < 6; g++) begin
            if (g > 0) applyStimulus(5'b11111, 1'b0, 1'b0, 2);
            o = (mOwner < 0) ? 0 : mOwner;
            applyStimulus(5'b11111, 1'b0, 1'b0, 2);
            dropMask    = 5'b11111;
            dropMask[o] = 1'b0;
            applyStimulus(dropMask, 1'b0, 1'b0, 1);
        end
        applyStimulus(5'b00000, 1'b0, 1'b0, 4);
        checkOutput("rr order length", obsIds.size(), 6);
        for (int i = 0; i < 6 && i < obsIds.size(); i++) begin
            checkOutput("rr order", obsIds[i], expOrder[i]);
        end

        // Busy gating in IDLE.
        applyStimulus(5'b00100, 1'b1, 1'b0, 10);
        checkOutput("busy holds grant off", int'(bus_grant), 0);
        applyStimulus(5'b00100, 1'b0, 1'b0, 1);
        checkOutput("grant after busy drops", int'(bus_grant), 5'b00100);
        applyStimulus(5'b00000, 1'b0, 1'b0, 4);

        // Watchdog: master 3 never drops; master 4 joins and wins afterwards.
        applyStimulus(5'b01000, 1'b0, 1'b0, 1);
        holdCycles = 0;
        for (int i = 0; i < 20; i++) begin
            if (bus_grant != 5'b01000) break;
            holdCycles++;
            applyStimulus(5'b11000, 1'b0, 1'b0, 1);
        end
        checkOutput("watchdog grant length", holdCycles, TIMEOUT);
        checkOutput("watchdog pulse", int'(timeout_err), 1);
        checkOutput("watchdog id", int'(timeout_id), 3);
        applyStimulus(5'b11000, 1'b0, 1'b0, 1);
        checkOutput("watchdog pulse width", int'(timeout_err), 0);
        applyStimulus(5'b11000, 1'b0, 1'b0, 1);
        checkOutput("next winner after revoke", int'(bus_grant), 5'b10000);
        applyStimulus(5'b00000, 1'b0, 1'b0, 4);

        // Drop on the same cycle the watchdog would fire: no timeout.
        applyStimulus(5'b00010, 1'b0, 1'b0, 1);
        applyStimulus(5'b00010, 1'b0, 1'b0, TIMEOUT - 1);
        checkOutput("last allowed cycle grant", int'(bus_grant), 5'b00010);
        applyStimulus(5'b00000, 1'b0, 1'b0, 1);
        checkOutput("drop beats watchdog grant", int'(bus_grant), 0);
        checkOutput("drop beats watchdog pulse", int'(timeout_err), 0);
        checkOutput("timeout id retained", int'(timeout_id), 3);
        applyStimulus(5'b00000, 1'b0, 1'b0, 3);

        // Reset mid-ownership, then pointer restarts at master 0.
        applyStimulus(5'b00100, 1'b0, 1'b0, 3);
        checkOutput("owner before reset", int'(bus_grant), 5'b00100);
        applyStimulus(5'b00110, 1'b0, 1'b1, 1);
        checkOutput("reset drops grant", int'(bus_grant), 0);
        checkOutput("reset no pulse", int'(timeout_err), 0);
        applyStimulus(5'b00110, 1'b0, 1'b0, 1);
        checkOutput("post-reset winner", int'(bus_grant), 5'b00010);
        applyStimulus(5'b00000, 1'b0, 1'b0, 4);

        // Randomized traffic: level-held requests of random length, random busy, rare resets.
        r = '0;
        for (int m = 0; m < NUM_REQ; m++) holdCnt[m] = 0;
        for (int c = 0; c < 3000; c++) begin
            for (int m = 0; m < NUM_REQ; m++) begin
                if (holdCnt[m] > 0) holdCnt[m]--;
                if (holdCnt[m] == 0) begin
                    r[m]       = ~r[m];
                    holdCnt[m] = r[m] ? int'($urandom_range(1, 14)) : int'($urandom_range(1, 6));
                end
            end
            applyStimulus(r, ($urandom_range(0, 3) == 0), ($urandom_range(0, 199) == 0), 1);
        end
        applyStimulus(5'b00000, 1'b0, 1'b0, 6);

        checkOutput("grant events drained", grantQ.size(), 0);
        checkOutput("release events drained", releaseQ.size(), 0);
        checkOutput("timeout events drained", timeoutQ.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
